// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared definitions for the two-master data-memory arbiter:
//   - arb_state_t : arbiter FSM states (IDLE / ISSUE / WAIT / DONE)
//   - owner_t     : which master owns the current transaction
//                   (OWN_P = processor core, OWN_D = secondary master)
//   - default address / data widths and read latency
//   - one-hot grant encodings shared by rr_arb2 and the top level
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Default geometry of the shared data memory.
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // RAM read latency, address sample to data valid. Legal range 1..3,
    // so a 2-bit countdown is always wide enough.
    localparam int DEF_RD_LAT = 1;
    localparam int WAIT_CNT_W = 2;

    // One-hot grant vector: bit 0 = processor, bit 1 = secondary master.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_P    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Map a one-hot grant onto the owner encoding. Only meaningful when the
    // grant is non-zero; an empty grant maps to OWN_P and is never used.
    function automatic owner_t grant_owner(input logic [1:0] grant);
        return grant[1] ? OWN_D : OWN_P;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//
// Two-way round-robin arbiter, purely combinational. A lone requester is
// granted outright; on a tie the requester that was NOT served last wins.
// Kept generic so it can be reused for future IO-port arbitration.
//
// Ports:
//   req_p       in  1  request from requester 0 (processor)
//   req_d       in  1  request from requester 1 (secondary master)
//   last_grant  in  1  owner served most recently (OWN_P / OWN_D)
//   en          in  1  arbitration enable; grant is all-zero when low
//   grant       out 2  one-hot grant (bit 0 = P, bit 1 = D)
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       req_p,
    input  logic       req_d,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would infer a latch.
        grant = GNT_NONE;
        if (en) begin
            if (req_p && req_d) begin
                grant = (last_grant == OWN_D) ? GNT_P : GNT_D;
            end else if (req_p) begin
                grant = GNT_P;
            end else if (req_d) begin
                grant = GNT_D;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous single-port data RAM between the processor core
// (p_*) and a secondary master such as a loader or debug port (d_*). One
// request is accepted per arbitration cycle, served with exactly one RAM
// cycle, and completed with a one-cycle ack. Ties alternate round-robin.
//
//   Write : grant in IDLE (cycle N), mem_wren + ack in N+1.
//   Read  : grant in IDLE (cycle N), address on RAM in N+1,
//           ack + rdata in N+2+RD_LAT.
//
// Parameters:
//   ADDR_W  address width              (default 16)
//   DATA_W  data width                 (default 16)
//   RD_LAT  RAM read latency, 1..3     (default 1)
//
// Ports:
//   Clock            in   rising-edge clock
//   Reset            in   synchronous active-high reset
//   p_req/d_req      in   request, held until the matching ack
//   p_wr/d_wr        in   1 = write, 0 = read; stable while req
//   p_addr/d_addr    in   address; stable while req
//   p_wdata/d_wdata  in   write data; stable while req
//   p_ack/d_ack      out  one-cycle completion pulse
//   p_rdata/d_rdata  out  read data, valid with a read ack, held until that
//                         port's next read completes
//   mem_addr         out  RAM address (registered)
//   mem_wdata        out  RAM write data (registered)
//   mem_wren         out  RAM write enable (registered)
//   mem_rdata        in   RAM read data
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              Clock,
    input  logic              Reset,

    input  logic              p_req,
    input  logic              p_wr,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_ack,
    output logic [DATA_W-1:0] p_rdata,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_CNT_W-1:0] RD_LAT_CNT = WAIT_CNT_W'(RD_LAT);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE    = WAIT_CNT_W'(1);

    arb_state_t              state;
    arb_state_t              state_nxt;
    owner_t                  owner;        // master of the transaction in flight
    owner_t                  last_grant;   // master granted most recently
    logic                    wr_q;         // transaction in flight is a write
    logic [WAIT_CNT_W-1:0]   wait_cnt;

    logic                    arb_en;
    logic [1:0]              grant;
    logic                    granted;
    logic                    wait_last;
    logic                    svc_ack;

    logic                    sel_wr;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;

    // -----------------------------------------------------------------------
    // Arbitration: only IDLE accepts new work, so a request that shows up
    // mid-transaction simply waits here until the current one has acked.
    // -----------------------------------------------------------------------
    assign arb_en = (state == IDLE);

    rr_arb2 u_arb (
        .req_p      (p_req),
        .req_d      (d_req),
        .last_grant (last_grant),
        .en         (arb_en),
        .grant      (grant)
    );

    assign granted = (grant != GNT_NONE);

    // Request fields of whichever master is being granted this cycle.
    always_comb begin
        sel_wr    = p_wr;
        sel_addr  = p_addr;
        sel_wdata = p_wdata;
        if (grant == GNT_D) begin
            sel_wr    = d_wr;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
    end

    // Final WAIT cycle: the RAM output is valid now. The <= form also lets
    // an out-of-range RD_LAT of 0 terminate instead of wrapping.
    assign wait_last = (wait_cnt <= CNT_ONE);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        // NOTE: clocked state uses non-blocking (<=) assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (granted) state_nxt = ISSUE;
            ISSUE:   state_nxt = wr_q ? IDLE : WAIT;
            WAIT:    if (wait_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Acks: a write completes in ISSUE, a read in DONE. Decoded from
    // registered state, so only the owner ever sees a pulse.
    // -----------------------------------------------------------------------
    always_comb begin
        svc_ack = ((state == ISSUE) && wr_q) || (state == DONE);
        p_ack   = svc_ack && (owner == OWN_P);
        d_ack   = svc_ack && (owner == OWN_D);
    end

    // -----------------------------------------------------------------------
    // Datapath: transaction latch, RAM control registers, wait counter and
    // per-port read-data registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            owner      <= OWN_P;
            last_grant <= OWN_D;     // processor wins the first tie
            wr_q       <= 1'b0;
            wait_cnt   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wren   <= 1'b0;
            p_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            // Write enable is a single-cycle strobe covering ISSUE only;
            // address and data hold their last values.
            mem_wren <= 1'b0;

            case (state)
                IDLE: begin
                    if (granted) begin
                        owner      <= grant_owner(grant);
                        last_grant <= grant_owner(grant);
                        wr_q       <= sel_wr;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_wren   <= sel_wr;
                    end
                end

                ISSUE: begin
                    // The RAM samples the address at the end of ISSUE; the
                    // countdown spans the cycles until its data is valid.
                    if (!wr_q) begin
                        wait_cnt <= RD_LAT_CNT;
                    end
                end

                WAIT: begin
                    if (wait_last) begin
                        wait_cnt <= '0;
                        if (owner == OWN_P) begin
                            p_rdata <= mem_rdata;
                        end else begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_ONE;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances: dut (RD_LAT=1, both ports exercised) and dut3
// (RD_LAT=3, processor port only), each with its own behavioural RAM.
// Logical ports: 0 = dut.p, 1 = dut.d, 2 = dut3.p.
//
// A single driver process pops per-port stimulus queues and holds req until
// the ack. Each issued transaction also pushes its expected result (data and
// ack cycle, hand-computed) into a per-port scoreboard queue that the
// negedge monitor pops on every ack.
//
// Cycle numbering: cyc increments on every rising edge. A transaction issued
// at the falling edge of cycle C raises req in C+1; if the arbiter is idle
// that is the arbitration cycle N = C+1.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } tx_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;   // write data for writes, read data for reads
        int          cyc;    // cycle in which the ack must be seen
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          ack_count;

    logic [2:0]  req;
    logic [2:0]  wr;
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic [2:0]  ack;
    logic [15:0] rdata [3];

    logic        d3_req;
    logic        d3_wr;
    logic [15:0] d3_addr;
    logic [15:0] d3_wdata;
    logic        d3_ack;
    logic [15:0] d3_rdata;

    logic [15:0] m_addr  [2];
    logic [15:0] m_wdata [2];
    logic [1:0]  m_wren;
    logic [15:0] m_rdata [2];

    tx_t  drv_q [3][$];
    exp_t sb_q  [3][$];

    // -----------------------------------------------------------------------
    // DUTs
    // -----------------------------------------------------------------------
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut (
        .Clock     (clk),
        .Reset     (rst),
        .p_req     (req[0]),
        .p_wr      (wr[0]),
        .p_addr    (addr[0]),
        .p_wdata   (wdata[0]),
        .p_ack     (ack[0]),
        .p_rdata   (rdata[0]),
        .d_req     (req[1]),
        .d_wr      (wr[1]),
        .d_addr    (addr[1]),
        .d_wdata   (wdata[1]),
        .d_ack     (ack[1]),
        .d_rdata   (rdata[1]),
        .mem_addr  (m_addr[0]),
        .mem_wdata (m_wdata[0]),
        .mem_wren  (m_wren[0]),
        .mem_rdata (m_rdata[0])
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) dut3 (
        .Clock     (clk),
        .Reset     (rst),
        .p_req     (req[2]),
        .p_wr      (wr[2]),
        .p_addr    (addr[2]),
        .p_wdata   (wdata[2]),
        .p_ack     (ack[2]),
        .p_rdata   (rdata[2]),
        .d_req     (d3_req),
        .d_wr      (d3_wr),
        .d_addr    (d3_addr),
        .d_wdata   (d3_wdata),
        .d_ack     (d3_ack),
        .d_rdata   (d3_rdata),
        .mem_addr  (m_addr[1]),
        .mem_wdata (m_wdata[1]),
        .mem_wren  (m_wren[1]),
        .mem_rdata (m_rdata[1])
    );

    // -----------------------------------------------------------------------
    // Clock and cycle counter
    // -----------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Behavioural RAMs (256 words each). Unwritten words read a fixed
    // pattern: 0x0003 -> 0x1234, 0x00FF -> 0xBEEF, else {a, ~a} on a[7:0].
    // Instance 0 has a 1-stage read pipe, instance 1 a 3-stage one.
    // -----------------------------------------------------------------------
    bit   [15:0] ram     [2][256];
    bit          ram_vld [2][256];
    logic [15:0] rd_pipe [2][3];

    function automatic logic [15:0] init_val(input logic [7:0] a);
        if (a == 8'h03) return 16'h1234;
        if (a == 8'hFF) return 16'hBEEF;
        return {a, ~a};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rd_pipe[k][0] <= ram_vld[k][m_addr[k][7:0]] ? ram[k][m_addr[k][7:0]]
                                                       : init_val(m_addr[k][7:0]);
            rd_pipe[k][1] <= rd_pipe[k][0];
            rd_pipe[k][2] <= rd_pipe[k][1];
            if (m_wren[k] === 1'b1) begin
                ram[k][m_addr[k][7:0]]     <= m_wdata[k];
                ram_vld[k][m_addr[k][7:0]] <= 1'b1;
            end
        end
    end

    assign m_rdata[0] = rd_pipe[0][0];
    assign m_rdata[1] = rd_pipe[1][2];

    // -----------------------------------------------------------------------
    // Checking helpers
    // -----------------------------------------------------------------------
    function automatic string pname(input int i);
        case (i)
            0:       return "p";
            1:       return "d";
            default: return "p3";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)",
                     name, act, exp_v, cyc);
        end
    endtask

    task automatic issue(input int port, input bit w, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] exp_d,
                         input int lat, input bit expect_ack);
        tx_t  t;
        exp_t e;
        t.wr = w; t.addr = a; t.wdata = wd;
        drv_q[port].push_back(t);
        if (expect_ack) begin
            e.wr   = w;
            e.addr = a;
            e.data = w ? wd : exp_d;
            e.cyc  = cyc + lat;
            sb_q[port].push_back(e);
        end
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int pending;
        pending = 0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            pending = 0;
            for (int i = 0; i < 3; i++) begin
                pending += sb_q[i].size() + drv_q[i].size();
            end
            if (pending == 0) break;
        end
        check({tag, "_pending_at_timeout"}, pending, 0);
        for (int i = 0; i < 3; i++) begin
            sb_q[i].delete();
            drv_q[i].delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mem_addr"},  {16'h0, m_addr[0]},  32'h0);
        check({tag, "_mem_wdata"}, {16'h0, m_wdata[0]}, 32'h0);
        check({tag, "_mem_wren"},  32'(m_wren[0]),      32'h0);
        check({tag, "_p_ack"},     32'(ack[0]),         32'h0);
        check({tag, "_d_ack"},     32'(ack[1]),         32'h0);
        check({tag, "_p_rdata"},   {16'h0, rdata[0]},   32'h0);
        check({tag, "_d_rdata"},   {16'h0, rdata[1]},   32'h0);
    endtask

    // -----------------------------------------------------------------------
    // Driver: raise req one cycle after a transaction is queued, drop it the
    // cycle after its ack (or immediately present the next queued one).
    // -----------------------------------------------------------------------
    initial begin : driver
        bit [2:0] seen;
        tx_t      t;
        req = '0;
        wr  = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        forever begin
            @(negedge clk);
            seen = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (rst || seen[i]) req[i] = 1'b0;
                if (!rst && !req[i] && drv_q[i].size() > 0) begin
                    t        = drv_q[i].pop_front();
                    req[i]   = 1'b1;
                    wr[i]    = t.wr;
                    addr[i]  = t.addr;
                    wdata[i] = t.wdata;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Monitor: pop and compare on every ack, away from the rising edge.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        int   k;
        for (int i = 0; i < 3; i++) begin
            if (ack[i] === 1'b1) begin
                k = (i == 2) ? 1 : 0;
                ack_count++;
                if (sb_q[i].size() == 0) begin
                    check({pname(i), "_unexpected_ack"}, 32'(ack[i]), 32'h0);
                end else begin
                    e = sb_q[i].pop_front();
                    check({pname(i), "_ack_cycle"}, cyc, e.cyc);
                    if (e.wr) begin
                        check({pname(i), "_wr_mem_wren"},  32'(m_wren[k]),      32'h1);
                        check({pname(i), "_wr_mem_addr"},  {16'h0, m_addr[k]},  {16'h0, e.addr});
                        check({pname(i), "_wr_mem_wdata"}, {16'h0, m_wdata[k]}, {16'h0, e.data});
                    end else begin
                        check({pname(i), "_rd_rdata"},    {16'h0, rdata[i]}, {16'h0, e.data});
                        check({pname(i), "_rd_mem_wren"}, 32'(m_wren[k]),    32'h0);
                    end
                end
            end
        end
        if (ack[0] === 1'b1 || ack[1] === 1'b1) begin
            check("ack_overlap", 32'(ack[0] & ack[1]), 32'h0);
        end
        if (m_wren[0] === 1'b1 && ack[0] !== 1'b1 && ack[1] !== 1'b1) begin
            check("stray_mem_wren", 32'(m_wren[0]), 32'h0);
        end
        if (m_wren[1] === 1'b1 && ack[2] !== 1'b1 && d3_ack !== 1'b1) begin
            check("stray_mem_wren_lat3", 32'(m_wren[1]), 32'h0);
        end
    end

    // -----------------------------------------------------------------------
    // Directed stimulus
    // -----------------------------------------------------------------------
    initial begin : stimulus
        int base;
        n_checks  = 0;
        n_fail    = 0;
        ack_count = 0;
        d3_req    = 1'b0;
        d3_wr     = 1'b0;
        d3_addr   = '0;
        d3_wdata  = '0;
        rst       = 1'b1;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset: both ports held with two reads each -> P,D,P,D,
        // one read every 4 cycles.
        issue(0, 1'b0, 16'h0020, 16'h0, 16'h20DF,  4, 1'b1);
        issue(1, 1'b0, 16'h0021, 16'h0, 16'h21DE,  8, 1'b1);
        issue(0, 1'b0, 16'h0030, 16'h0, 16'h30CF, 12, 1'b1);
        issue(1, 1'b0, 16'h0031, 16'h0, 16'h31CE, 16, 1'b1);
        drain("tie", 60);

        // Single write: wren/addr/wdata/ack in N+1.
        issue(0, 1'b1, 16'h0010, 16'h00FF, 16'h0, 2, 1'b1);
        drain("single_write", 30);

        // Single read on D: ack + rdata at N+3.
        issue(1, 1'b0, 16'h0003, 16'h0, 16'h1234, 4, 1'b1);
        drain("single_read", 30);

        // Read back the earlier write through P.
        issue(0, 1'b0, 16'h0010, 16'h0, 16'h00FF, 4, 1'b1);
        drain("readback", 30);

        // Late arrival: D raised during P's WAIT, served right after P.
        issue(0, 1'b0, 16'h0040, 16'h0, 16'h40BF, 4, 1'b1);
        repeat (2) @(negedge clk);
        issue(1, 1'b0, 16'h0050, 16'h0, 16'h50AF, 6, 1'b1);
        drain("late_arrival", 30);
        check("late_p_rdata_held", {16'h0, rdata[0]}, 32'h40BF);
        check("late_d_rdata",      {16'h0, rdata[1]}, 32'h50AF);

        // Reset in WAIT: no ack, reset values next cycle, tie goes to P.
        base = ack_count;
        issue(0, 1'b0, 16'h0060, 16'h0, 16'h0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("mid_read_reset");
        repeat (4) @(negedge clk);
        check("aborted_read_acks", ack_count, base);
        issue(0, 1'b0, 16'h0020, 16'h0, 16'h20DF, 4, 1'b1);
        issue(1, 1'b0, 16'h0021, 16'h0, 16'h21DE, 8, 1'b1);
        drain("tie_after_abort", 40);

        // RD_LAT=3: read acks at N+5, queued write acks 2 cycles later.
        issue(2, 1'b0, 16'h00FF, 16'h0,    16'hBEEF, 6, 1'b1);
        issue(2, 1'b1, 16'h0011, 16'hA55A, 16'h0,    8, 1'b1);
        drain("lat3_read_write", 40);
        issue(2, 1'b0, 16'h0011, 16'h0,    16'hA55A, 6, 1'b1);
        drain("lat3_readback", 30);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the processor's single synchronous data memory (address / write-data / write-enable / read-data) between the processor core and a secondary master, such as a program loader or debug/IO port. It sits between both masters and the RAM and owns all memory control signals. It serialises accesses with a round-robin grant, issues exactly one RAM cycle per granted request, and returns read data after a fixed latency.

## Interface
Parameters:
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 16: memory word width.
- `RD_LAT`, default 1: RAM read latency in cycles, from address sample to data valid. Legal range is 1..3.

Ports:
- `Clock` in 1: the single clock. All logic is rising-edge.
- `Reset` in 1: synchronous, active-high reset.
- `p_req` in 1: processor request. Held until `p_ack`.
- `p_wr` in 1: processor request is a write (1) or a read (0). Stable while `p_req`.
- `p_addr` in `ADDR_W`: processor address. Stable while `p_req`.
- `p_wdata` in `DATA_W`: processor write data. Stable while `p_req`.
- `p_ack` out 1: one-cycle completion pulse.
- `p_rdata` out `DATA_W`: processor read data. Valid when `p_ack` is high for a read; held until that port's next read completes.
- `d_req`, `d_wr`, `d_addr`, `d_wdata`, `d_ack`, `d_rdata`: secondary master. Identical semantics to the `p_` signals.
- `mem_addr` out `ADDR_W`: RAM address (registered).
- `mem_wdata` out `DATA_W`: RAM write data (registered).
- `mem_wren` out 1: RAM write enable (registered).
- `mem_rdata` in `DATA_W`: RAM read data.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`, `DONE`.
- **`IDLE`**:
  - Exactly one of `p_req` or `d_req` asserted: grant that one.
  - Both asserted: grant the port not served last (`last_grant` flag).
  - On grant: latch owner, `wr`, addr and wdata into the `mem_*` registers, then go to `ISSUE`.
- **`ISSUE`**: the `mem_*` registers drive the RAM.
  - Write: `mem_wren`=1 and owner ack=1 this cycle, then `IDLE`.
  - Read: `mem_wren`=0, load the wait counter with `RD_LAT`, go to `WAIT`.
- **`WAIT`**: count down. On the cycle the count reaches its last value, capture `mem_rdata` into the owner's rdata register, then go to `DONE`.
- **`DONE`**: owner ack=1 with rdata valid, then `IDLE`.
- `last_grant` updates on every grant. After reset, `last_grant` = secondary, so the processor wins the first tie.
- The non-owner's ack stays 0 throughout. A request arriving mid-transaction waits in `IDLE` arbitration.
- Outside `ISSUE`, `mem_wren`=0. `mem_addr` and `mem_wdata` hold their last values.
- A requester dropping `req` before ack is a protocol violation. The arbiter completes the transaction anyway; the ack is ignored by the master.

## Timing
- Request sampled in `IDLE` at cycle N:
  - Write: `mem_wren`=1 and ack=1 in cycle N+1. Latency is 1.
  - Read: `mem_addr` valid in cycle N+1; ack and rdata in cycle N+2+`RD_LAT`. Latency is 2+`RD_LAT` (3 at the default).
- The cycle after ack is `IDLE`. Each transaction therefore occupies 1 arbitration cycle plus its service cycles.
- Back-to-back throughput:
  - Writes: one every 2 cycles.
  - Reads: one every 3+`RD_LAT` cycles.
- Simultaneous requests alternate strictly while both stay asserted.
- **Reset**:
  - Effect: state=`IDLE`, `mem_addr`=0, `mem_wdata`=0, `mem_wren`=0, `p_ack`=`d_ack`=0, `p_rdata`=`d_rdata`=0, wait counter=0, `last_grant`=secondary.
  - Reset mid-transaction aborts the transaction with no ack.
  - A write in `ISSUE` when reset is asserted still presents `mem_wren` for that cycle; `mem_wren` is cleared from the next cycle onward.

## Structure
- Shared package holds:
  - the state enum (`IDLE`/`ISSUE`/`WAIT`/`DONE`);
  - the owner encoding (`OWN_P`=0, `OWN_D`=1);
  - the default widths (16/16).
- Sub-module `rr_arb2`:
  - Inputs: two req lines, `last_grant`, an enable.
  - Output: a one-hot grant.
  - Purely combinational; reusable for future IO-port arbitration.
- Top level holds the FSM, wait counter, `mem_*` registers and per-port rdata registers. Expected size is 150–250 lines.

## Test plan
- **Single write**: `p_req`=1, `p_wr`=1, `p_addr`=0x0010, `p_wdata`=0x00FF.
  - Required: `mem_wren`=1, `mem_addr`=0x0010, `mem_wdata`=0x00FF, `p_ack`=1, all in cycle N+1.
  - Required: `d_ack` stays 0.
- **Single read** (`RD_LAT`=1): RAM[0x0003]=0x1234, `d_req` read of 0x0003.
  - Required: `d_ack`=1 and `d_rdata`=0x1234 at N+3.
  - Required: `mem_wren` stays 0.
- **Tie after reset**: `p_req` and `d_req` asserted in the same cycle and held (4 reads).
  - Required: grant order is P, D, P, D.
  - Required: acks never overlap.
  - Required: each port's rdata matches its own address.
- **Late arrival**: `d_req` raised during a P read's `WAIT`.
  - Required: D is served immediately after P's `DONE` + `IDLE`.
  - Required: `p_rdata` is unchanged by D's read.
- **Reset mid-read**: `Reset` pulsed in `WAIT`.
  - Required: no ack.
  - Required: all outputs at reset values next cycle.
  - Required: the next tie grants P.
- **`RD_LAT`=3 build**: read of 0x00FF.
  - Required: ack at N+5.
  - Required: a write issued next acks 2 cycles after the read's ack.
